// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with valid/ready
// ports on both sides, an occupancy count, a synchronous flush and sticky
// error flags. Pointers carry one extra wrap bit so that full and empty are
// distinguishable without a separate flag. All control state lives in
// sync_fifo_reg instances; only the storage array is a plain memory.

// Generic enabled register with synchronous active-high clear.
module sync_fifo_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Clear on reset, otherwise load d_i whenever enabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

module sync_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [1:0]            err_o
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    // Only power-of-two depths of at least two work with the wrap-bit scheme
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic [PTR_WIDTH-1:0] wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic [1:0]           err_q;
    logic [1:0]           err_d;

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];

    // Full and empty come straight from registered pointers, so the
    // ready/valid outputs never see a combinational path from any input.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) &&
                   (wr_ptr_q[PTR_WIDTH-1] != rd_ptr_q[PTR_WIDTH-1]);

    assign wr_ready_o = ~full;
    assign rd_valid_o = ~empty;
    assign count_o    = count_q;
    assign err_o      = err_q;
    assign rd_data_o  = mem[rd_idx];

    assign push = wr_valid_i & wr_ready_o;
    assign pop  = rd_valid_o & rd_ready_i;

    // Next pointer, count and error state; flush wins over both handshakes
    // and freezes the error flags for that cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
            err_d = err_q | {rd_ready_i & ~rd_valid_o, wr_valid_i & ~wr_ready_o};
        end
    end

    sync_fifo_reg #(.WIDTH(PTR_WIDTH)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .d_i   (wr_ptr_d),
        .q_o   (wr_ptr_q)
    );

    sync_fifo_reg #(.WIDTH(PTR_WIDTH)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .d_i   (rd_ptr_d),
        .q_o   (rd_ptr_q)
    );

    sync_fifo_reg #(.WIDTH(CNT_WIDTH)) u_count (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .d_i   (count_d),
        .q_o   (count_q)
    );

    sync_fifo_reg #(.WIDTH(2)) u_err (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .d_i   (err_d),
        .q_o   (err_q)
    );

    // Storage write; the array is deliberately left out of reset
    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) begin
            mem[wr_idx] <= wr_data_i;
        end
    end

    // The occupancy counter must always agree with the pointer distance
    count_matches_ptrs: assert property (
        @(posedge clk_i) disable iff (rst_i)
        count_q == (wr_ptr_q - rd_ptr_q)
    );

    // Occupancy never exceeds the number of storage slots
    count_in_range: assert property (
        @(posedge clk_i) disable iff (rst_i)
        count_q <= CNT_WIDTH'(DEPTH)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scoreboard bench for sync_fifo (DEPTH=4, 8-bit).
// Stimulus pushes expected read data into a queue; an independent monitor
// pops and compares whenever the DUT completes a read handshake.

module tb_sync_fifo;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       flush_i;
    logic       wr_valid_i;
    logic       wr_ready_o;
    logic [7:0] wr_data_i;
    logic       rd_valid_o;
    logic       rd_ready_i;
    logic [7:0] rd_data_o;
    logic [2:0] count_o;
    logic [1:0] err_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_data_i  (wr_data_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .count_o    (count_o),
        .err_o      (err_o)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs, let one rising edge consume them, return 1 after it
    task automatic applyStimulus(input logic rs, input logic fl, input logic wv,
                                 input logic [7:0] wd, input logic rr,
                                 input logic exp_accept);
        rst_i      = rs;
        flush_i    = fl;
        wr_valid_i = wv;
        wr_data_i  = wd;
        rd_ready_i = rr;
        if (exp_accept) exp_q.push_back(wd);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        if (rs || fl) exp_q.delete();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input int cnt, input logic rv,
                               input logic wr, input logic [1:0] err);
        checkValue({tag, " count_o"},    int'(count_o),    cnt);
        checkValue({tag, " rd_valid_o"}, int'(rd_valid_o), int'(rv));
        checkValue({tag, " wr_ready_o"}, int'(wr_ready_o), int'(wr));
        checkValue({tag, " err_o"},      int'(err_o),      int'(err));
    endtask

    // Monitor: every completed read handshake must match the oldest expected entry
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && flush_i === 1'b0 && rd_valid_o === 1'b1 && rd_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL scoreboard: read of %0h with nothing expected at %0t", rd_data_o, $time);
            end else begin
                checkValue("read data", int'(rd_data_o), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_i      = 1'b1;
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        wr_data_i  = 8'h00;
        rd_ready_i = 1'b0;

        // Reset then idle
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();
        checkOutput("reset", 0, 1'b0, 1'b1, 2'b00);

        // Fill to full, overflow attempt, drain in order
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);
        checkOutput("fill1", 1, 1'b1, 1'b1, 2'b00);
        checkValue("fill1 rd_data_o", int'(rd_data_o), 'h11);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1);
        checkOutput("fill2", 2, 1'b1, 1'b1, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1);
        checkOutput("fill3", 3, 1'b1, 1'b1, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1);
        checkOutput("fill4", 4, 1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("overflow", 4, 1'b1, 1'b0, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain1", 3, 1'b1, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain2", 2, 1'b1, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain3", 1, 1'b1, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain4", 0, 1'b0, 1'b1, 2'b01);

        // Steady state at two entries, push and pop every cycle, pointers wrap
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hE0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hE1, 1'b0, 1'b1);
        checkOutput("prefill", 2, 1'b1, 1'b1, 2'b01);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b1, 1'b1);
            checkOutput("stream", 2, 1'b1, 1'b1, 2'b01);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("stream drain1", 1, 1'b1, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("stream drain2", 0, 1'b0, 1'b1, 2'b01);

        // Read while empty, then 1-cycle write-to-read latency
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("underflow", 0, 1'b0, 1'b1, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
        checkOutput("fwft", 1, 1'b1, 1'b1, 2'b11);
        checkValue("fwft rd_data_o", int'(rd_data_o), 'hA5);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("fwft pop", 0, 1'b0, 1'b1, 2'b11);

        // Flush with a concurrent push discards everything, keeps err_o
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1);
        checkOutput("pre-flush", 3, 1'b1, 1'b1, 2'b11);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        checkOutput("flush", 0, 1'b0, 1'b1, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
        checkOutput("post-flush push", 1, 1'b1, 1'b1, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post-flush pop", 0, 1'b0, 1'b1, 2'b11);

        // Reset beats flush and push while full with err_o=01
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("re-reset", 0, 1'b0, 1'b1, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
        checkOutput("full+err", 4, 1'b1, 1'b0, 2'b01);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        checkOutput("reset priority", 0, 1'b0, 1'b1, 2'b00);
        idle();
        checkOutput("after reset", 0, 1'b0, 1'b1, 2'b00);

        checkValue("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, first-word-fall-through FIFO built on the team's register primitives.
- Valid/ready write port faces the producer; valid/ready read port faces the consumer.
- Used as the standard elastic buffer between pipeline stages and as the shared queue inside IP blocks such as UART, SPI and DMA.
- Provides an occupancy count, a synchronous flush and sticky error flags.

Parameters:
- DATA_WIDTH, 8: width of each entry in bits (>=1).
- DEPTH, 4: number of entries; must be a power of two, >=2; elaboration fails otherwise.
- CNT_WIDTH, $clog2(DEPTH)+1: width of count_o. Derived; not overridable.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- flush_i  input  1  synchronous clear of contents, active-high.
- wr_valid_i  input  1  producer presents wr_data_i.
- wr_ready_o  output  1  FIFO can accept an entry (= not full).
- wr_data_i  input  DATA_WIDTH  write data.
- rd_valid_o  output  1  rd_data_o holds the oldest entry (= not empty).
- rd_ready_i  input  1  consumer takes rd_data_o.
- rd_data_o  output  DATA_WIDTH  oldest entry, first-word-fall-through.
- count_o  output  CNT_WIDTH  current occupancy, 0..DEPTH.
- err_o  output  2  sticky flags: bit0 = write attempted while full, bit1 = read attempted while empty.

Behaviour:
- Reset (rst_i=1 at rising edge), registered values after the edge:
  - wr_ptr = 0, rd_ptr = 0.
  - count_o = 0, rd_valid_o = 0, wr_ready_o = 1, err_o = 2'b00.
  - Storage array is not reset.
  - rst_i has priority over flush_i and over both handshakes.
- Pointers:
  - Width is log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Empty: pointers are fully equal.
  - Full: index bits are equal and wrap bits differ.
  - Pointers wrap modulo 2*DEPTH with no special handling.
- Handshakes:
  - push = wr_valid_i & wr_ready_o.
  - pop = rd_valid_o & rd_ready_i.
- Push:
  - mem[wr_ptr index] <= wr_data_i; wr_ptr increments.
  - Data is visible on rd_data_o the cycle after the write edge when the FIFO was empty (1-cycle write-to-read latency).
- Pop:
  - rd_ptr increments; rd_data_o is combinationally mem[rd_ptr index].
  - rd_data_o is don't-care while rd_valid_o=0 and must not be checked.
- Simultaneous push and pop (only possible when 0 < count < DEPTH): both occur; count unchanged.
- When full:
  - wr_ready_o=0, so a push cannot occur even if a pop happens in the same cycle.
  - wr_ready_o depends only on registered state, never on rd_ready_i.
- When empty:
  - rd_valid_o=0, so a pop cannot occur.
  - No bypass: a write to an empty FIFO is not readable in the same cycle.
- count_o:
  - Registered; +1 on push-only, -1 on pop-only, unchanged otherwise.
  - Always equals wr_ptr - rd_ptr modulo 2*DEPTH.
- Outputs wr_ready_o, rd_valid_o and count_o are registered-state functions: no combinational path from any input.
- err_o:
  - bit0 sets when wr_valid_i=1 & wr_ready_o=0; bit1 sets when rd_ready_i=1 & rd_valid_o=0.
  - Both bits stay set until rst_i.
  - flush_i does not clear err_o.
- flush_i (rst_i=0):
  - Pointers and count go to 0 at the edge; a push or pop in the same cycle is discarded.
  - err_o is not updated from that cycle's inputs.
- Reset mid-operation: all in-flight entries are lost; the next cycle after reset deassertion behaves as empty.

Test Plan:
- Reset then idle, DEPTH=4, DATA_WIDTH=8 -> count_o=0, rd_valid_o=0, wr_ready_o=1, err_o=00.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles -> count_o = 1,2,3,4; wr_ready_o=0 after the fourth edge. A fifth push of 0x55 is rejected and err_o=01. Popping four entries returns 0x11,0x22,0x33,0x44 in order, then rd_valid_o=0.
- Hold count at 2, push and pop every cycle for 20 cycles with an incrementing pattern 0x00..0x13 -> count_o stays 2; output sequence equals input delayed by 2 pops; pointers wrap at least twice with no loss.
- With the FIFO empty, assert rd_ready_i -> no pop, count_o=0, err_o bit1 sets. Then write 0xA5 -> rd_valid_o=1 and rd_data_o=0xA5 exactly one cycle later.
- With 3 entries, assert flush_i together with push 0x77 -> next cycle count_o=0, rd_valid_o=0; err_o keeps its prior value; a subsequent push/pop of 0x77 returns 0x77.
- Assert rst_i and flush_i with a push while full and err_o=01 -> after the edge all outputs are at reset values, including err_o=00.
